serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//  Framed serial transmitter: accepts a parallel word via valid/ready, shifts it out LSB-first on a
//  single bit line as start bit, data bits, optional parity and stop bit(s), each held CLKS_PER_BIT
//  clocks. Drives the serial stream sampled by our flip-flop/shift-register receive paths.
// PARAMETERS
//  DATA_W       8  data bits per frame (>=1)
//  CLKS_PER_BIT 4  clocks each serial bit is held (>=1)
//  STOP_BITS    1  number of stop bits (1 or 2)
// PORTS
//  clk       in   1       rising-edge clock
//  reset_n   in   1       asynchronous active-low reset
//  clear_n   in   1       synchronous active-low clear; aborts any frame
//  tx_data   in   DATA_W  word to send; sampled only on accept
//  tx_valid  in   1       tx_data valid
//  tx_ready  out  1       block can accept (IDLE and clear_n=1)
//  tx_line   out  1       serial output, idle high, registered
//  tx_busy   out  1       frame in progress (any state but IDLE)
//  tx_done   out  1       one-cycle pulse: frame fully sent
// BEHAVIOUR
//  - Reset (reset_n=0, async): state IDLE; tx_line=1, tx_busy=0, tx_done=0, counters/shift reg 0;
//    tx_ready=1 once reset_n=1 and clear_n=1.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. Each state except IDLE lasts
//    CLKS_PER_BIT clocks per bit; DATA lasts DATA_W bits, STOP lasts STOP_BITS bits.
//  - Accept: tx_valid && tx_ready at edge k; tx_data captured into shift reg; tx_line=0 from k+1.
//  - Data LSB first; shift reg shifts right at each bit boundary.
//  - Last STOP cycle -> IDLE; tx_done=1 for exactly the first IDLE cycle, tx_busy=0 in that cycle.
//  - Back-to-back: accept allowed in the tx_done cycle -> exactly one idle-high cycle between frames.
//  - tx_valid while busy: ignored, no capture, tx_ready=0; tx_data changes while busy have no effect.
//  - clear_n=0 (sync, overrides accept): next edge -> IDLE, tx_line=1, tx_busy=0, no tx_done pulse;
//    tx_ready=0 while clear_n=0.
//  - reset_n asserted mid-frame: immediate IDLE values; frame lost, no tx_done.
//  - Bit counter width $clog2(DATA_W+1); tick counter width $clog2(CLKS_PER_BIT+1); tick counter wraps
//    to 0 at CLKS_PER_BIT-1; CLKS_PER_BIT=1 means a new bit every clock.
//  - Frame length L = (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT, P=1 with parity else 0.
// CONFIGURATION
//  - SERIAL_TX_PARITY_EN defined: PARITY state after DATA sends even parity (XOR of captured word),
//    held CLKS_PER_BIT clocks.
//  - Undefined: no PARITY state; DATA goes directly to STOP; P=0.
// STRUCTURE
//  - Package serial_pkg: state encoding localparams (IDLE/START/DATA/PARITY/STOP), line levels
//    IDLE_LVL=1, START_LVL=0, STOP_LVL=1; shared with the matching receiver.
//  - Sub-module serial_bit_timer: tick counter, outputs bit_end pulse on cycle CLKS_PER_BIT-1,
//    restarted on accept and on clear.
// TESTING (DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1)
//  1. reset_n=0 for 10 cycles, clear_n=1 -> tx_line=1, tx_busy=0, tx_done=0; tx_ready=1 after release.
//  2. Send 8'hA5, accepted at k -> line 0 on k+1..k+4, bits 1,0,1,0,0,1,0,1 for 4 cycles each
//     (k+5..k+36), stop 1 on k+37..k+40, tx_done only at k+41; with PARITY_EN parity 0 on
//     k+37..k+40, stop k+41..k+44, tx_done k+45.
//  3. tx_valid held high, 8'h00 then 8'hFF -> second accepted in tx_done cycle, one idle-high cycle,
//     second start bit next cycle; parity (if enabled) 0 for both.
//  4. tx_valid pulsed with 8'h3C mid-frame -> tx_ready=0, word ignored, current frame unchanged.
//  5. clear_n=0 one cycle during data bit 3 -> tx_line=1, tx_busy=0 next cycle, no tx_done;
//     repeat with reset_n=0 mid-stop bit -> immediate idle outputs.
//  6. CLKS_PER_BIT=1, 50 $random words, random tx_valid -> line matches bit-level model, one
//     tx_done per accepted word.

Source files
------------

// File: rtl/serial_pkg.sv
// Package serial_pkg
//  Shared definitions for the framed serial transmitter and its matching receiver.
//  Contents:
//    ST_*       FSM state encodings (IDLE, START, DATA, PARITY, STOP)
//    *_LVL      serial line levels for idle, start and stop bits
package serial_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_START  = 3'd1;
  localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
  localparam logic [ST_W-1:0] ST_PARITY = 3'd3;
  localparam logic [ST_W-1:0] ST_STOP   = 3'd4;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/serial_bit_timer.sv
// Module serial_bit_timer
//  Counts the clocks of one serial bit and flags the last clock of each bit.
//  Ports:
//    clk      in   rising-edge clock
//    reset_n  in   asynchronous active-low reset
//    restart  in   forces the tick counter back to 0 (frame accept or clear)
//    run      in   count while a frame is in progress
//    bit_end  out  high on the last clock (CLKS_PER_BIT-1) of the current bit
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  input  logic run,
  output logic bit_end
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] tick_q;
  logic [TW-1:0] tick_d;

  always_comb begin
    tick_d = tick_q;
    if (restart) begin
      tick_d = '0;
    end else if (run) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
    end
  end

  // A restart wins over a pending boundary so a clear never advances the FSM.
  assign bit_end = run && !restart && (tick_q == TICK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Module serial_frame_tx
//  Framed serial transmitter. A word accepted over tx_valid/tx_ready is sent
//  LSB first as start bit, DATA_W data bits, optional even parity and
//  STOP_BITS stop bits, each bit held CLKS_PER_BIT clocks.
//  Build option: define SERIAL_TX_PARITY_EN to insert the even-parity bit.
//  Ports:
//    clk       in   rising-edge clock
//    reset_n   in   asynchronous active-low reset
//    clear_n   in   synchronous active-low clear, aborts any frame
//    tx_data   in   word to send, sampled on accept only
//    tx_valid  in   tx_data valid
//    tx_ready  out  can accept (idle and not clearing)
//    tx_line   out  registered serial output, idle high
//    tx_busy   out  frame in progress
//    tx_done   out  one-cycle pulse in the first idle cycle after a frame
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic [ST_W-1:0]   state_q,   state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q,   shift_d;
  logic              line_q,    line_d;
  logic              done_q,    done_d;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q,  parity_d;
`endif

  logic accept;
  logic bit_end;

  assign tx_ready = (state_q == ST_IDLE) && clear_n;
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx_line  = line_q;
  assign tx_done  = done_q;
  assign accept   = tx_valid && tx_ready;

  serial_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (accept || !clear_n),
    .run     (tx_busy),
    .bit_end (bit_end)
  );

  // line_d is the level for the cycle after the edge, so tx_line stays a
  // plain flop output while still changing exactly at bit boundaries.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    line_d    = line_q;
    done_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (!clear_n) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      line_d    = IDLE_LVL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          line_d = IDLE_LVL;
          if (accept) begin
            state_d   = ST_START;
            shift_d   = tx_data;
            bit_cnt_d = '0;
            line_d    = START_LVL;
`ifdef SERIAL_TX_PARITY_EN
            parity_d  = ^tx_data;
`endif
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_d = ST_DATA;
            line_d  = shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            shift_d = shift_q >> 1;
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
              state_d   = ST_PARITY;
              line_d    = parity_q;
`else
              state_d   = ST_STOP;
              line_d    = STOP_LVL;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              line_d    = shift_d[0];
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state_d = ST_STOP;
            line_d  = STOP_LVL;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            if (bit_cnt_q == STOP_LAST) begin
              state_d   = ST_IDLE;
              bit_cnt_d = '0;
              line_d    = IDLE_LVL;
              done_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          line_d    = IDLE_LVL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      line_q    <= IDLE_LVL;
      done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      line_q    <= line_d;
      done_q    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench tb_serial_frame_tx
//  Drives two transmitters (CLKS_PER_BIT=4 and CLKS_PER_BIT=1, DATA_W=8,
//  STOP_BITS=1) and compares every output each cycle with a frame model
//  that derives the expected line level from the position inside the frame.
//  Honours SERIAL_TX_PARITY_EN like the design.
module tb_serial_frame_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int DW = 8;
  localparam int L0 = (1 + DW + P + 1) * 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       clear_n = 1'b1;
  logic [7:0] data0 = '0, data1 = '0;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic       ready0, line0, busy0, done0;
  logic       ready1, line1, busy1, done1;

  int n_vec = 0;
  int n_err = 0;

  // frame model state, index 0 = CLKS_PER_BIT 4, index 1 = CLKS_PER_BIT 1
  int         m_busy[2];
  int         m_done[2];
  int         m_t[2];
  int         m_acc[2];
  logic [7:0] m_word[2];
  int         dcnt1 = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .clear_n(clear_n), .tx_data(data0),
    .tx_valid(valid0), .tx_ready(ready0), .tx_line(line0), .tx_busy(busy0),
    .tx_done(done0));

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .clear_n(clear_n), .tx_data(data1),
    .tx_valid(valid1), .tx_ready(ready1), .tx_line(line1), .tx_busy(busy1),
    .tx_done(done1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cpb_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // Level of frame bit b: 0 start, 1..DW data LSB first, then parity, then stop.
  function automatic logic frame_bit(input logic [7:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    if (P == 1 && b == DW + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic model_edge(input int d, input logic clr, input logic v, input logic [7:0] w);
    int len;
    len = (1 + DW + P + 1) * cpb_of(d);
    if (!clr) begin
      m_busy[d] = 0;
      m_done[d] = 0;
    end else if (m_busy[d] != 0) begin
      m_t[d]++;
      m_done[d] = 0;
      if (m_t[d] == len) begin
        m_busy[d] = 0;
        m_done[d] = 1;
      end
    end else begin
      m_done[d] = 0;
      if (v) begin
        m_busy[d] = 1;
        m_t[d]    = 0;
        m_word[d] = w;
        m_acc[d]++;
      end
    end
  endtask

  function automatic logic exp_line(input int d);
    if (m_busy[d] == 0) return 1'b1;
    return frame_bit(m_word[d], m_t[d] / cpb_of(d));
  endfunction

  task automatic check_all(input logic with_ready);
    check("line0", line0, exp_line(0));
    check("busy0", busy0, m_busy[0]);
    check("done0", done0, m_done[0]);
    check("line1", line1, exp_line(1));
    check("busy1", busy1, m_busy[1]);
    check("done1", done1, m_done[1]);
    if (with_ready) begin
      check("ready0", ready0, (m_busy[0] == 0) && clear_n);
      check("ready1", ready1, (m_busy[1] == 0) && clear_n);
    end
  endtask

  task automatic step(input logic clr, input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1);
    clear_n = clr;
    valid0  = v0;
    data0   = d0;
    valid1  = v1;
    data1   = d1;
    @(posedge clk);
    model_edge(0, clr, v0, d0);
    model_edge(1, clr, v1, d1);
    @(negedge clk);
    if (done1) dcnt1++;
    check_all(1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic hard_reset(input int cycles);
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0;
      m_done[d] = 0;
    end
    check_all(1'b0);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_all(1'b0);
    end
    reset_n = 1'b1;
  endtask

  task automatic run_to(input int t);
    int n;
    n = 0;
    while (m_t[0] != t && m_busy[0] != 0 && n < 200) begin
      idle(1);
      n++;
    end
    check("run_to_pos", m_t[0], t);
  endtask

  initial begin
    int n;
    int base;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_done[d] = 0; m_t[d] = 0; m_acc[d] = 0; m_word[d] = '0;
    end

    // 1: reset held 10 cycles, ready after release
    #2;
    hard_reset(10);
    idle(2);

    // 2: 8'hA5 frame, done exactly L cycles after the accept
    step(1'b1, 1'b1, 8'hA5, 1'b0, 8'h00);
    n = 0;
    while (!done0 && n < 200) begin
      idle(1);
      n++;
    end
    check("a5_done_latency", n, L0);
    idle(2);

    // 3: valid held high, 8'h00 then 8'hFF back to back
    base = m_acc[0];
    step(1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
    n = 0;
    while (m_acc[0] < base + 2 && n < 200) begin
      step(1'b1, 1'b1, 8'hFF, 1'b0, 8'h00);
      n++;
    end
    check("b2b_accepts", m_acc[0] - base, 2);
    idle(L0 + 3);

    // 4: valid pulsed mid-frame is ignored
    step(1'b1, 1'b1, 8'h55, 1'b0, 8'h00);
    idle(10);
    step(1'b1, 1'b1, 8'h3C, 1'b0, 8'h00);
    idle(L0);

    // 5a: clear during data bit 3
    step(1'b1, 1'b1, 8'h96, 1'b0, 8'h00);
    run_to((1 + 3) * 4 + 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    idle(L0 + 2);

    // 5b: async reset during the stop bit
    step(1'b1, 1'b1, 8'h0F, 1'b0, 8'h00);
    run_to((1 + DW + P) * 4 + 1);
    hard_reset(2);
    idle(3);

    // random traffic on the slow instance with occasional clears
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 50) != 0, $urandom % 2, 8'($urandom), 1'b0, 8'h00);
    end
    idle(L0 + 2);

    // 6: CLKS_PER_BIT=1, 50 random words with random valid
    base  = m_acc[1];
    dcnt1 = 0;
    n     = 0;
    while (m_acc[1] - base < 50 && n < 5000) begin
      step(1'b1, 1'b0, 8'h00, ($urandom % 3) != 0, 8'($urandom));
      n++;
    end
    check("cpb1_words_sent", m_acc[1] - base, 50);
    idle(20);
    check("cpb1_done_per_word", dcnt1, m_acc[1] - base);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
